clock_display_scan: RTL

Downstream display stage of the digital clock. It samples the `hour`, `minute` and `second` values produced by the time-keeping/set-up state machine once per scan frame. It converts each value to two BCD digits with a sequential subtract-by-ten converter. It then time-multiplexes six active-low seven-segment digits (HH.MM.SS) on the board.

---
 rtl/clock_display_scan.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/clock_display_scan.sv
// Six-digit HH.MM.SS seven-segment scanner. Samples hour/minute/second once per
// frame, converts them to BCD by repeated subtraction, and double-buffers the digits.
module clock_display_scan #(
  parameter int unsigned REFRESH_DIV = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] hour,
  input  logic [13:0] minute,
  input  logic [13:0] second,
  output logic [6:0]  seg,
  output logic [5:0]  an,
  output logic        dp
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [3:0] DIGIT_DASH = 4'hA;

  typedef enum logic [1:0] {IDLE, CONV_H, CONV_M, CONV_S} conv_state_e;

  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         idx_q, idx_d;
  logic               frame_start;
  conv_state_e        state_q, state_d;
  logic [13:0]        work_q, work_d;
  logic [3:0]         tens_q, tens_d;
  logic [13:0]        min_s_q, min_s_d;
  logic [13:0]        sec_s_q, sec_s_d;
  logic [5:0][3:0]    shadow_q, shadow_d;
  logic [5:0][3:0]    disp_q, disp_d;
  logic [3:0]         store_hi, store_lo;
  logic               store_en;
  logic [6:0]         seg_q;
  logic [5:0]         an_q;
  logic               dp_q;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:       seg_encode = 7'b1000000;
      4'd1:       seg_encode = 7'b1111001;
      4'd2:       seg_encode = 7'b0100100;
      4'd3:       seg_encode = 7'b0110000;
      4'd4:       seg_encode = 7'b0011001;
      4'd5:       seg_encode = 7'b0010010;
      4'd6:       seg_encode = 7'b0000010;
      4'd7:       seg_encode = 7'b1111000;
      4'd8:       seg_encode = 7'b0000000;
      4'd9:       seg_encode = 7'b0010000;
      DIGIT_DASH: seg_encode = 7'b0111111;
      default:    seg_encode = 7'b1111111;
    endcase
  endfunction

  assign frame_start = (idx_q == 3'd0) && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    idx_d = idx_q;
    if (cnt_q == CW'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  // The frame-start edge already shows the freshly transferred buffer, so no
  // frame ever mixes two samples.
  assign disp_d = frame_start ? shadow_q : disp_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path through the case infers a latch.
    state_d  = state_q;
    work_d   = work_q;
    tens_d   = tens_q;
    min_s_d  = min_s_q;
    sec_s_d  = sec_s_q;
    shadow_d = shadow_q;
    store_hi = DIGIT_DASH;
    store_lo = DIGIT_DASH;
    store_en = 1'b0;
    if (state_q == IDLE) begin
      if (frame_start) begin
        state_d = CONV_H;
        work_d  = hour;
        tens_d  = 4'd0;
        min_s_d = minute;
        sec_s_d = second;
      end
    end else begin
      if (work_q >= 14'd100) begin
        store_en = 1'b1;
      end else if (work_q >= 14'd10) begin
        work_d = work_q - 14'd10;
        tens_d = tens_q + 4'd1;
      end else begin
        store_hi = tens_q;
        store_lo = work_q[3:0];
        store_en = 1'b1;
      end
      if (store_en) begin
        tens_d = 4'd0;
        case (state_q)
          CONV_H: begin
            shadow_d[5] = store_hi;
            shadow_d[4] = store_lo;
            work_d      = min_s_q;
            state_d     = CONV_M;
          end
          CONV_M: begin
            shadow_d[3] = store_hi;
            shadow_d[2] = store_lo;
            work_d      = sec_s_q;
            state_d     = CONV_S;
          end
          default: begin
            shadow_d[1] = store_hi;
            shadow_d[0] = store_lo;
            state_d     = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      idx_q    <= 3'd0;
      state_q  <= IDLE;
      work_q   <= '0;
      tens_q   <= '0;
      min_s_q  <= '0;
      sec_s_q  <= '0;
      // NOTE: the digit buffers are reset because they are displayed straight after reset.
      shadow_q <= '0;
      disp_q   <= '0;
      seg_q    <= 7'h7F;
      an_q     <= 6'h3F;
      dp_q     <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      state_q  <= state_d;
      work_q   <= work_d;
      tens_q   <= tens_d;
      min_s_q  <= min_s_d;
      sec_s_q  <= sec_s_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      seg_q    <= seg_encode(disp_d[idx_q]);
      an_q     <= ~(6'b000001 << idx_q);
      dp_q     <= !((idx_q == 3'd2) || (idx_q == 3'd4));
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
